// File: rtl/mac_accumulator_if.sv
// ----------------------------------------------------------------------------
// mac_accumulator_if
//
// Bundles both handshakes of the dot-product accumulator: the product stream
// coming from the multiplier and the result stream going to the next stage.
//
// Signals
//   in_valid   upstream -> acc   in_prod / in_last are valid
//   in_ready   acc -> upstream   accumulator can take a beat this cycle
//   in_prod    upstream -> acc   unsigned product, 2*bw bits
//   in_last    upstream -> acc   beat closes the current vector
//   out_valid  acc -> consumer   result register holds a finished vector
//   out_ready  consumer -> acc   consumer takes the result this cycle
//   out_acc    acc -> consumer   vector sum, 2*bw+GUARD bits, wrapping
//   out_count  acc -> consumer   beats in the vector
//   out_ovf    acc -> consumer   accumulator carried out during the vector
//   out_trunc  acc -> consumer   vector closed by length limit, not in_last
//
// Modports
//   master  environment side (drives the product stream, consumes results)
//   slave   accumulator side
// ----------------------------------------------------------------------------
interface mac_accumulator_if #(
    parameter int bw     = 16,
    parameter int GUARD  = 8,
    parameter int MAXLEN = 256
);
    localparam int PW = 2 * bw;
    localparam int AW = PW + GUARD;
    localparam int CW = $clog2(MAXLEN) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          in_last;

    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic [CW-1:0] out_count;
    logic          out_ovf;
    logic          out_trunc;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf, out_trunc
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf, out_trunc
    );
endinterface

// File: rtl/mac_accumulator.sv
// ----------------------------------------------------------------------------
// mac_accumulator
//
// Sums vectors of unsigned products (dot products) arriving from the
// pipelined multiplier. Each finished vector is parked in a one-entry result
// register that the next stage drains through its own valid/ready handshake.
// A new vector may accumulate while the previous result waits; only when the
// result register is full and not being drained is the input stalled.
//
// Ports
//   CLK     clock, all state changes on the rising edge
//   RESETn  asynchronous active-low reset
//   bus     mac_accumulator_if.slave (product stream in, result stream out)
//
// Parameters
//   bw      operand width of the upstream multiplier (product is 2*bw bits)
//   GUARD   extra accumulator MSBs above the product width
//   MAXLEN  maximum beats per vector (>= 2); reaching it closes the vector
// ----------------------------------------------------------------------------
module mac_accumulator #(
    parameter int bw     = 16,
    parameter int GUARD  = 8,
    parameter int MAXLEN = 256
) (
    input  logic              CLK,
    input  logic              RESETn,
    mac_accumulator_if.slave  bus
);

    localparam int PW = 2 * bw;
    localparam int AW = PW + GUARD;
    localparam int CW = $clog2(MAXLEN) + 1;

    localparam logic [CW-1:0] MAXLEN_C = CW'(MAXLEN);

    typedef enum logic {
        S_IDLE = 1'b0,   // no vector open
        S_ACC  = 1'b1    // vector open, accumulating
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e        state_q, state_d;

    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_acc_q, out_acc_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          out_ovf_q, out_ovf_d;
    logic          out_trunc_q, out_trunc_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic in_ready;
    logic accept;

    // Ready looks only at the result register and out_ready: a full result
    // register that is being drained this cycle frees its slot in time for a
    // closing beat to reload it on the same edge.
    assign in_ready = !(out_valid_q && !bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // ------------------------------------------------------------------
    // FSM output logic: the running values a new beat builds on.
    // In IDLE a beat starts from zero, so a fresh vector and a continuing
    // one share the same adder and the carry of a first beat is always 0.
    // ------------------------------------------------------------------
    logic [AW-1:0] acc_base;
    logic [CW-1:0] cnt_base;
    logic          ovf_base;

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a
        // default first; a path that skips an assignment infers a latch.
        acc_base = '0;
        cnt_base = '0;
        ovf_base = 1'b0;
        case (state_q)
            S_ACC: begin
                acc_base = acc_q;
                cnt_base = cnt_q;
                ovf_base = ovf_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath for the beat being offered this cycle
    // ------------------------------------------------------------------
    logic [AW:0]   sum;        // one extra bit to catch the carry out
    logic [CW-1:0] cnt_inc;
    logic          ovf_inc;
    logic          hit_max;
    logic          closing;

    assign sum     = {1'b0, acc_base} + (AW+1)'(bus.in_prod);
    assign cnt_inc = cnt_base + CW'(1);
    assign ovf_inc = ovf_base | sum[AW];

    // Beat number MAXLEN closes the vector even without in_last.
    assign hit_max = (cnt_inc == MAXLEN_C);
    assign closing = bus.in_last || hit_max;

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && !closing) state_d = S_ACC;
            S_ACC:   if (accept && closing)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator next state. After a closing beat acc/cnt/ovf keep stale
    // values; the IDLE base above masks them for the next vector.
    // ------------------------------------------------------------------
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            acc_d = sum[AW-1:0];
            cnt_d = cnt_inc;
            ovf_d = ovf_inc;
        end
    end

    // ------------------------------------------------------------------
    // Result register next state. A closing beat wins over a drain in the
    // same cycle, so back-to-back vectors keep out_valid high.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        out_trunc_d = out_trunc_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept && closing) begin
            out_valid_d = 1'b1;
            out_acc_d   = sum[AW-1:0];
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_inc;
            out_trunc_d = !bus.in_last;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!RESETn) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_trunc = out_trunc_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// ----------------------------------------------------------------------------
// tb_mac_accumulator
//
// Drives vectors of products into mac_accumulator (bw=16, GUARD=1, MAXLEN=4)
// and compares every drained result against a scoreboard queue filled by a
// reference model at the moment each beat is accepted. Directed scenarios
// add spot checks of handshake timing and known result values.
// ----------------------------------------------------------------------------
module tb_mac_accumulator;

    localparam int BW     = 16;
    localparam int GUARD  = 1;
    localparam int MAXLEN = 4;
    localparam int PW     = 2 * BW;
    localparam int AW     = PW + GUARD;

    typedef struct {
        logic [AW-1:0] acc;
        int            cnt;
        logic          ovf;
        logic          trunc;
    } exp_t;

    logic clk;
    logic rst_n;

    mac_accumulator_if #(.bw(BW), .GUARD(GUARD), .MAXLEN(MAXLEN)) bus ();

    mac_accumulator #(.bw(BW), .GUARD(GUARD), .MAXLEN(MAXLEN)) dut (
        .CLK    (clk),
        .RESETn (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests   = 0;
    int n_fail    = 0;
    int n_pushed  = 0;
    int n_results = 0;

    exp_t exp_q[$];

    // Reference model state
    logic [AW-1:0] m_acc;
    int            m_cnt;
    logic          m_ovf;
    bit            m_open;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [PW-1:0] prod, input logic last);
        logic [AW:0] s;
        exp_t        e;
        if (!m_open) begin
            m_acc = '0;
            m_cnt = 0;
            m_ovf = 1'b0;
        end
        s     = {1'b0, m_acc} + {{(GUARD+1){1'b0}}, prod};
        m_acc = s[AW-1:0];
        m_ovf = m_ovf | s[AW];
        m_cnt = m_cnt + 1;
        if (last || m_cnt == MAXLEN) begin
            e.acc   = m_acc;
            e.cnt   = m_cnt;
            e.ovf   = m_ovf;
            e.trunc = !last;
            exp_q.push_back(e);
            n_pushed++;
            m_open = 0;
        end else begin
            m_open = 1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that took the beat.
    task automatic send_beat(input logic [PW-1:0] prod, input logic last);
        int   waited;
        logic rdy;
        waited       = 0;
        rdy          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_prod  = prod;
        bus.in_last  = last;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 100) begin
                check("accept_wait_cycles", 64'(waited), 64'd100);
                break;
            end
        end
        if (rdy) model_accept(prod, last);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: a result transfers on the edge after a negedge with
    // out_valid && out_ready, so it is counted exactly once.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            check("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_results++;
                check("sb_acc",   64'(bus.out_acc),   64'(e.acc));
                check("sb_count", 64'(bus.out_count), 64'(e.cnt));
                check("sb_ovf",   64'(bus.out_ovf),   64'(e.ovf));
                check("sb_trunc", 64'(bus.out_trunc), 64'(e.trunc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit drv_done;

    initial begin
        m_open        = 0;
        m_acc         = '0;
        m_cnt         = 0;
        m_ovf         = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_acc",   64'(bus.out_acc),   64'd0);
        check("rst_out_count", 64'(bus.out_count), 64'd0);
        check("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
        check("rst_out_trunc", 64'(bus.out_trunc), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        #1 rst_n = 1'b1;
        idle_cycles(1);
        bus.out_ready = 1'b1;

        // ---------------- basic vector ----------------
        send_beat(32'd15, 1'b0);
        send_beat(32'd100, 1'b0);
        check("basic_no_early_valid", 64'(bus.out_valid), 64'd0);
        send_beat(32'hFFFE_0001, 1'b1);
        check("basic_valid", 64'(bus.out_valid), 64'd1);
        check("basic_acc",   64'(bus.out_acc),   64'd4294836340);
        check("basic_count", 64'(bus.out_count), 64'd3);
        idle_cycles(2);

        // ---------------- overflow ----------------
        send_beat(32'hFFFE_0001, 1'b0);
        send_beat(32'hFFFE_0001, 1'b0);
        send_beat(32'hFFFE_0001, 1'b1);
        check("ovf_acc",   64'(bus.out_acc),   64'd4294574083);
        check("ovf_flag",  64'(bus.out_ovf),   64'd1);
        check("ovf_count", 64'(bus.out_count), 64'd3);
        send_beat(32'd7, 1'b1);
        check("ovf_next_acc",  64'(bus.out_acc), 64'd7);
        check("ovf_next_flag", 64'(bus.out_ovf), 64'd0);
        idle_cycles(2);

        // ---------------- truncation ----------------
        for (int i = 0; i < 4; i++) send_beat(32'd1, 1'b0);
        check("trunc_valid", 64'(bus.out_valid), 64'd1);
        check("trunc_acc",   64'(bus.out_acc),   64'd4);
        check("trunc_count", 64'(bus.out_count), 64'd4);
        check("trunc_flag",  64'(bus.out_trunc), 64'd1);
        send_beat(32'd1, 1'b0);
        send_beat(32'd1, 1'b1);
        check("trunc_reopen_count", 64'(bus.out_count), 64'd2);
        check("trunc_reopen_flag",  64'(bus.out_trunc), 64'd0);
        idle_cycles(2);

        // ---------------- backpressure ----------------
        bus.out_ready = 1'b0;
        send_beat(32'd2, 1'b1);
        check("bp_first_valid", 64'(bus.out_valid), 64'd1);
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        fork
            begin
                send_beat(32'd3, 1'b0);
                send_beat(32'd4, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_held_valid", 64'(bus.out_valid), 64'd1);
                check("bp_held_acc",   64'(bus.out_acc),   64'd2);
                check("bp_stall",      64'(bus.in_ready),  64'd0);
                bus.out_ready = 1'b1;
                #1;
                check("bp_ready_comb", 64'(bus.in_ready), 64'd1);
            end
        join
        check("bp_second_acc",   64'(bus.out_acc),   64'd7);
        check("bp_second_count", 64'(bus.out_count), 64'd2);
        idle_cycles(2);

        // ---------------- back-to-back ----------------
        send_beat(32'd1, 1'b1);
        check("b2b_first_valid", 64'(bus.out_valid), 64'd1);
        check("b2b_first_acc",   64'(bus.out_acc),   64'd1);
        send_beat(32'd5, 1'b1);
        check("b2b_second_valid", 64'(bus.out_valid), 64'd1);
        check("b2b_second_acc",   64'(bus.out_acc),   64'd5);
        idle_cycles(2);

        // ---------------- reset mid-vector ----------------
        send_beat(32'd9, 1'b0);
        send_beat(32'd9, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_acc",   64'(bus.out_acc),   64'd0);
        check("mid_rst_count", 64'(bus.out_count), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready),  64'd1);
        #1 rst_n = 1'b1;
        m_open = 0;
        exp_q.delete();
        idle_cycles(1);
        send_beat(32'd6, 1'b1);
        check("post_rst_acc",   64'(bus.out_acc),   64'd6);
        check("post_rst_count", 64'(bus.out_count), 64'd1);
        idle_cycles(2);

        // ---------------- random traffic with random backpressure ----------------
        drv_done = 0;
        fork
            begin
                for (int v = 0; v < 30; v++) begin
                    int len;
                    len = int'($urandom_range(1, 6));
                    for (int b = 0; b < len; b++) begin
                        logic [PW-1:0] p;
                        case ($urandom_range(0, 3))
                            0:       p = '1;
                            1:       p = '0;
                            default: p = PW'($urandom);
                        endcase
                        send_beat(p, (b == len - 1));
                    end
                end
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) idle_cycles(1);
        idle_cycles(2);

        check("sb_drained",      64'(exp_q.size()), 64'd0);
        check("sb_result_count", 64'(n_results),    64'(n_pushed));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
